// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared control-bundle layout and stage occupancy states
package pipe_pkg;

  localparam int DRAM_WE_LSB      = 0;
  localparam int DRAM_WE_W        = 1;
  localparam int REG_WE_LSB       = 1;
  localparam int REG_WE_W         = 1;
  localparam int RWSEL_LSB        = 2;
  localparam int RWSEL_W          = 2;
  localparam int DRAM_EX_TYPE_LSB = 4;
  localparam int DRAM_EX_TYPE_W   = 3;

  // Control value of a bubble: every write enable deasserted
  localparam int CTRL_NOP = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous active-low reset
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - handshaked pipeline stage register with flush, optional skid entry and stall counter
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_data_dup,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);

  logic              head_valid_n;
  logic [CTRL_W-1:0] head_ctrl_n;
  logic [DATA_W-1:0] head_data_n;
  logic              stall_inc;

  // Separate register for the duplicate so each copy drives its own fan-out
  (* keep = "true" *) logic [DATA_W-1:0] data_dup_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_ctrl   <= NOP;
      out_data   <= '0;
      data_dup_q <= '0;
    end else begin
      out_valid  <= head_valid_n;
      out_ctrl   <= head_ctrl_n;
      out_data   <= head_data_n;
      data_dup_q <= head_data_n;
    end
  end

  assign out_data_dup = data_dup_q;

  generate
    if (SKID != 0) begin : g_skid
      state_t            state, state_n;
      logic              ready_q;
      logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_n;
      logic [DATA_W-1:0] skid_data, skid_data_n;
      logic              accept, pop;

      assign in_ready = ready_q;
      assign accept   = in_valid & ready_q;
      assign pop      = out_valid & out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state     <= ST_EMPTY;
          ready_q   <= 1'b1;
          skid_ctrl <= NOP;
          skid_data <= '0;
        end else begin
          state     <= state_n;
          ready_q   <= (state_n != ST_TWO);
          skid_ctrl <= skid_ctrl_n;
          skid_data <= skid_data_n;
        end
      end

      always_comb begin
        state_n      = state;
        head_valid_n = out_valid;
        head_ctrl_n  = out_ctrl;
        head_data_n  = out_data;
        skid_ctrl_n  = skid_ctrl;
        skid_data_n  = skid_data;
        if (flush_i) begin
          state_n      = ST_EMPTY;
          head_valid_n = 1'b0;
          head_ctrl_n  = NOP;
          skid_ctrl_n  = NOP;
        end else begin
          case (state)
            ST_EMPTY: begin
              if (accept) begin
                state_n      = ST_ONE;
                head_valid_n = 1'b1;
                head_ctrl_n  = in_ctrl;
                head_data_n  = in_data;
              end
            end
            ST_ONE: begin
              if (accept && !pop) begin
                state_n     = ST_TWO;
                skid_ctrl_n = in_ctrl;
                skid_data_n = in_data;
              end else if (accept && pop) begin
                head_ctrl_n = in_ctrl;
                head_data_n = in_data;
              end else if (pop) begin
                state_n      = ST_EMPTY;
                head_valid_n = 1'b0;
                head_ctrl_n  = NOP;
              end
            end
            ST_TWO: begin
              // in_ready is low here, so only a pop can move the FIFO
              if (pop) begin
                state_n     = ST_ONE;
                head_ctrl_n = skid_ctrl;
                head_data_n = skid_data;
                skid_ctrl_n = NOP;
              end
            end
            default: begin
              state_n      = ST_EMPTY;
              head_valid_n = 1'b0;
              head_ctrl_n  = NOP;
            end
          endcase
        end
      end
    end else begin : g_single
      logic accept, pop;

      assign in_ready = ~out_valid | out_ready;
      assign accept   = in_valid & in_ready;
      assign pop      = out_valid & out_ready;

      always_comb begin
        head_valid_n = out_valid;
        head_ctrl_n  = out_ctrl;
        head_data_n  = out_data;
        if (flush_i) begin
          head_valid_n = 1'b0;
          head_ctrl_n  = NOP;
        end else if (accept) begin
          head_valid_n = 1'b1;
          head_ctrl_n  = in_ctrl;
          head_data_n  = in_data;
        end else if (pop) begin
          head_valid_n = 1'b0;
          head_ctrl_n  = NOP;
        end
      end
    end
  endgenerate

  assign stall_inc = out_valid & ~out_ready;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - scoreboard bench for a skid instance (CNT_W=4) and a single-entry instance
module tb_pipe_stage_hs;

  localparam int CW = 8;
  localparam int DW = 64;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          flush[2];
  logic          in_valid[2];
  logic          in_ready[2];
  logic [CW-1:0] in_ctrl[2];
  logic [DW-1:0] in_data[2];
  logic          out_valid[2];
  logic          out_ready[2];
  logic [CW-1:0] out_ctrl[2];
  logic [DW-1:0] out_data[2];
  logic [DW-1:0] out_dup[2];
  logic [3:0]    stall_a;
  logic [15:0]   stall_b;

  // Index 0: SKID=1, CNT_W=4.  Index 1: SKID=0, CNT_W=16.
  ent_t sb[2][$];
  int   exp_stall[2];
  bit   pend_acc[2];
  ent_t pend_ent[2];
  bit   mon_en = 1'b0;
  int   passed = 0;
  int   total = 0;

  pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) dut_skid (
    .clk(clk), .rst_n(rst_n), .flush_i(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]),
    .out_data(out_data[0]), .out_data_dup(out_dup[0]), .stall_cnt(stall_a)
  );

  pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut_single (
    .clk(clk), .rst_n(rst_n), .flush_i(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]),
    .out_data(out_data[1]), .out_data_dup(out_dup[1]), .stall_cnt(stall_b)
  );

  task automatic check(int k, string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL dut%0d %s: got %0h expected %0h at %0t", k, name, act, exp, $time);
  endtask

  function automatic logic [CW-1:0] ctrl_of(logic [DW-1:0] d);
    return d[7:0] ^ d[15:8] ^ 8'hA5;
  endfunction

  // Capacity rule: skid stage holds two, single stage holds one but passes through on pop
  function automatic bit model_ready(int k, bit rdy);
    if (k == 0) return sb[k].size() < 2;
    return (sb[k].size() == 0) || rdy;
  endfunction

  task automatic set_in(int k, bit v, bit rdy, bit fl, logic [DW-1:0] d);
    in_valid[k]  = v;
    out_ready[k] = rdy;
    flush[k]     = fl;
    in_data[k]   = d;
    in_ctrl[k]   = ctrl_of(d);
    pend_ent[k]  = '{c: ctrl_of(d), d: d};
    pend_acc[k]  = v && model_ready(k, rdy);
  endtask

  task automatic idle(int k);
    set_in(k, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (flush[k]) sb[k].delete();
      else if (pend_acc[k]) sb[k].push_back(pend_ent[k]);
    end
    #1;
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      check(k, "rst_out_valid", out_valid[k], 0);
      check(k, "rst_out_ctrl", out_ctrl[k], 0);
      check(k, "rst_out_data", out_data[k], 0);
      check(k, "rst_out_dup", out_dup[k], 0);
    end
    check(0, "rst_stall", stall_a, 0);
    check(1, "rst_stall", stall_b, 0);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      sb[k].delete();
      exp_stall[k] = 0;
      idle(k);
    end
  endtask

  always @(negedge clk) begin
    bit   ev;
    ent_t f;
    int   cnt;
    int   mx;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        ev  = sb[k].size() > 0;
        cnt = (k == 0) ? int'(stall_a) : int'(stall_b);
        mx  = (k == 0) ? 15 : 65535;
        check(k, "out_valid", out_valid[k], ev);
        check(k, "in_ready", in_ready[k], model_ready(k, out_ready[k]));
        check(k, "stall_cnt", cnt, exp_stall[k]);
        if (ev) begin
          f = sb[k][0];
          check(k, "out_ctrl", out_ctrl[k], f.c);
          check(k, "out_data", out_data[k], f.d);
          check(k, "out_data_dup", out_dup[k], f.d);
          if (out_ready[k]) void'(sb[k].pop_front());
          else if (exp_stall[k] < mx) exp_stall[k]++;
        end else begin
          check(k, "bubble_ctrl", out_ctrl[k], 0);
        end
      end
    end
  end

  initial begin
    clear_model();
    for (int k = 0; k < 2; k++) pend_acc[k] = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check(0, "release_in_ready", in_ready[0], 1);
    check(1, "release_in_ready", in_ready[1], 1);
    mon_en = 1'b1;

    // Backpressure on the skid stage: A head, B skid, C held upstream
    idle(1);
    set_in(0, 1, 0, 0, 64'hA); cycle();
    set_in(0, 1, 0, 0, 64'hB); cycle();
    set_in(0, 1, 0, 0, 64'hC); cycle();
    set_in(0, 1, 0, 0, 64'hC); cycle();
    check(0, "bp_stall_3", stall_a, 3);
    check(0, "bp_in_ready_low", in_ready[0], 0);
    for (int i = 0; i < 4 && in_valid[0]; i++) begin
      if (pend_acc[0]) idle(0);
      else set_in(0, 1, 1, 0, 64'hC);
      cycle();
    end
    idle(0); cycle(); cycle(); cycle();

    // Streaming on both stages
    for (int i = 0; i < 16; i++) begin
      set_in(0, 1, 1, 0, 64'h10 + i);
      set_in(1, 1, 1, 0, 64'h10 + i);
      cycle();
    end
    idle(0); idle(1); cycle(); cycle();

    // Flush in state TWO together with an incoming entry
    set_in(0, 1, 0, 0, 64'h111); cycle();
    set_in(0, 1, 0, 0, 64'h222); cycle();
    set_in(0, 1, 0, 1, 64'h333); cycle();
    idle(0);
    check(0, "flush_out_valid", out_valid[0], 0);
    check(0, "flush_out_ctrl", out_ctrl[0], 0);
    check(0, "flush_in_ready", in_ready[0], 1);
    cycle();
    set_in(0, 1, 0, 0, 64'h444); cycle();
    set_in(0, 1, 1, 1, 64'h555); cycle();
    idle(0);
    check(0, "flush_pop_out_valid", out_valid[0], 0);
    cycle();

    // Saturation of the 4-bit stall counter
    set_in(0, 1, 0, 0, 64'h666); cycle();
    for (int i = 0; i < 20; i++) begin
      set_in(0, 0, 0, 0, '0);
      cycle();
    end
    check(0, "stall_saturated", stall_a, 15);
    idle(0); cycle(); cycle();

    // Single-entry stage: combinational in_ready and same-edge replacement
    set_in(1, 1, 0, 0, 64'h777); cycle();
    set_in(1, 0, 0, 0, '0);
    #1 check(1, "single_in_ready_low", in_ready[1], 0);
    cycle();
    set_in(1, 1, 1, 0, 64'h888);
    #1 check(1, "single_in_ready_comb", in_ready[1], 1);
    cycle();
    check(1, "single_replace_valid", out_valid[1], 1);
    check(1, "single_replace_data", out_data[1], 64'h888);
    idle(1); cycle(); cycle();

    // Randomized traffic, upstream holding unaccepted entries
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        bit rdy;
        bit fl;
        rdy = $urandom_range(0, 1) == 1;
        fl  = $urandom_range(0, 19) == 0;
        if (in_valid[k] && !pend_acc[k] && !flush[k])
          set_in(k, 1, rdy, fl, in_data[k]);
        else
          set_in(k, $urandom_range(0, 9) < 6, rdy, fl, {$urandom, $urandom});
      end
      cycle();
    end

    // Reset asserted mid-transfer with entries held
    set_in(0, 1, 0, 0, 64'h999);
    set_in(1, 1, 0, 0, 64'hAAA);
    cycle();
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    clear_model();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check(0, "mid_release_in_ready", in_ready[0], 1);
    check(1, "mid_release_in_ready", in_ready[1], 1);
    mon_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (in_valid[k] && !pend_acc[k])
          set_in(k, 1, $urandom_range(0, 1) == 1, 1'b0, in_data[k]);
        else
          set_in(k, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, {$urandom, $urandom});
      end
      cycle();
    end
    idle(0); idle(1); cycle(); cycle(); cycle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
